onchip_mem_stream_reader: RTL and testbench
===========================================

# onchip_mem_stream_reader

Avalon-MM read master that sweeps a contiguous window of the 1024 x 32-bit on-chip memory and emits the words as an Avalon-ST packet. It sits directly upstream of the pixel/display consumers and attaches to the memory's s1 slave port. The memory has a fixed 1-cycle read latency. The block keeps reads flowing under sink backpressure using a small credit-controlled FIFO.

## Interface
Parameters:
- ADDR_W, 10, memory word-address width (1024 words)
- DATA_W, 32, word width
- FIFO_DEPTH, 4, output FIFO entries (power of 2, at least 2)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a transfer; ignored while busy
- base_addr  in  ADDR_W  first word address, sampled on start
- length  in  ADDR_W+1  word count 0..1024, sampled on start
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse when the transfer completes
- mem_address  out  ADDR_W  to memory address
- mem_chipselect  out  1  read strobe, one word per asserted cycle
- mem_write  out  1  constant 0
- mem_byteenable  out  4  constant 4'hF
- mem_clken  out  1  constant 1
- mem_readdata  in  DATA_W  memory read data, valid 1 cycle after chipselect
- src_data  out  DATA_W  stream data (FIFO head)
- src_valid  out  1  stream valid
- src_ready  in  1  sink ready, zero ready-latency
- src_startofpacket  out  1  marks the first word
- src_endofpacket  out  1  marks the last word

## Operation
- Reset values: busy=0, done=0, mem_address=0, mem_chipselect=0, src_valid=0, src_startofpacket=0, src_endofpacket=0. The FIFO is empty, the counters are 0, and the state is IDLE.
- State machine: IDLE -> READ -> DRAIN -> IDLE.
- IDLE, start=1, length>0:
  - latch base_addr into rd_addr
  - latch length into issue_left and out_left
  - go to READ; busy=1
- IDLE, start=1, length=0:
  - done pulses the next cycle
  - busy stays 0
  - no reads and no stream words
- READ: issue a read (mem_chipselect=1, mem_address=rd_addr) in any cycle where issue_left>0 and (fifo_count + inflight) < FIFO_DEPTH.
  - inflight is 1 if a read was issued in the previous cycle, otherwise 0.
  - Each issue increments rd_addr modulo 1024 (1023 wraps to 0) and decrements issue_left.
  - When issue_left reaches 0, go to DRAIN.
- Returning data: mem_readdata is written into the FIFO on the cycle after the issue, unconditionally. The credit rule guarantees the FIFO never overflows.
- Stream output: src_valid = FIFO not empty; src_data = FIFO head. A word pops on src_valid & src_ready, and out_left decrements.
- SOP and EOP:
  - src_startofpacket=1 on the first word of the transfer.
  - src_endofpacket=1 when out_left==1.
  - For length 1, both are 1 on the same word.
- DRAIN: when the EOP word is accepted, go to IDLE next cycle with busy=0 and done=1 for one cycle.
- start is accepted only in IDLE. A start in the same cycle as done is ignored.
- Reset mid-transfer: immediately return to the reset values. FIFO contents are discarded and no done is produced.
- src_valid never deasserts without a pop, and src_data is stable while src_valid & !src_ready.

## Timing
- Cycle 0: start sampled. Cycle 1: first mem_chipselect with mem_address=base_addr.
- Cycle 2: mem_readdata valid; it is written to the FIFO at the end of the cycle. Cycle 3: first src_valid. Start-to-first-word latency is 3 cycles.
- With src_ready held at 1: one read issued and one word output per cycle. N words end with EOP in cycle N+2 and done in cycle N+3.
- With src_ready=0, issuing stops once fifo_count + inflight reaches FIFO_DEPTH. Issuing resumes in the cycle after a pop frees a slot.
- Boundary: fifo full and pop in the same cycle as a returning write is legal, and the count is unchanged.

## Test plan
- Memory preloaded with word[i]=i. Start with base_addr=0x010, length=8, src_ready=1 -> words 0x10..0x17 in cycles 3..10, SOP on 0x10, EOP on 0x17, done in cycle 11.
- base_addr=0x3FE, length=4 -> stream 0x3FE, 0x3FF, 0x000, 0x001; mem_address wraps cleanly.
- length=16 with src_ready toggling pseudo-randomly -> all 16 words delivered in order with no drop or duplicate. Never more than 4 reads outstanding plus buffered, and src_data is stable while stalled.
- length=0 -> done pulses in cycle 1, busy stays 0, mem_chipselect never asserted. length=1 -> single word carrying both SOP and EOP.
- Second start asserted while busy -> ignored; only the first transfer's words appear, with one done.
- Reset asserted mid-transfer with src_ready=0 -> all outputs at reset values at once. A following start with length=2 streams the correct 2 words with no stale data.

Source files
------------

// File: rtl/onchip_mem_stream_reader.sv
// Avalon-MM read master that sweeps a window of on-chip memory and emits it as an Avalon-ST
// packet. Reads are credit-limited so the output FIFO can never overflow under backpressure.
module onchip_mem_stream_reader #(
   parameter int unsigned ADDR_W     = 10,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [3:0]        mem_byteenable,
   output logic              mem_clken,
   input  logic [DATA_W-1:0] mem_readdata,
   output logic [DATA_W-1:0] src_data,
   output logic              src_valid,
   input  logic              src_ready,
   output logic              src_startofpacket,
   output logic              src_endofpacket
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam int unsigned LenW = ADDR_W + 1;

   typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] rd_addr_q;
   logic [LenW-1:0]   issue_left_q;
   logic [LenW-1:0]   out_left_q;
   logic              inflight_q;
   logic              first_q;
   logic              done_q;
   logic [PtrW-1:0]   wr_ptr_q;
   logic [PtrW-1:0]   rd_ptr_q;
   logic [CntW-1:0]   count_q;
   logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

   logic            issue;
   logic            push;
   logic            pop;
   logic            last_pop;
   logic [CntW-1:0] credit_used;

   // A read may only go out if its data is guaranteed a FIFO slot on return.
   always_comb begin
      credit_used = count_q + CntW'(inflight_q);
      issue       = (state_q == StRead) && (issue_left_q != '0) &&
                    (credit_used < CntW'(FIFO_DEPTH));
      push        = inflight_q;
      pop         = (count_q != '0) && src_ready;
      last_pop    = pop && (out_left_q == LenW'(1));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         rd_addr_q    <= '0;
         issue_left_q <= '0;
         out_left_q   <= '0;
         inflight_q   <= 1'b0;
         first_q      <= 1'b0;
         done_q       <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
      end else begin
         done_q     <= 1'b0;
         inflight_q <= issue;
         count_q    <= count_q + CntW'(push) - CntW'(pop);
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_q   <= rd_ptr_q + PtrW'(1);
            out_left_q <= out_left_q - LenW'(1);
            first_q    <= 1'b0;
         end
         if (issue) begin
            rd_addr_q    <= rd_addr_q + ADDR_W'(1);
            issue_left_q <= issue_left_q - LenW'(1);
         end
         unique case (state_q)
            StIdle: begin
               // done_q high means the previous transfer is retiring this cycle.
               if (start && !done_q) begin
                  if (length != '0) begin
                     rd_addr_q    <= base_addr;
                     issue_left_q <= length;
                     out_left_q   <= length;
                     first_q      <= 1'b1;
                     state_q      <= StRead;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            StRead: begin
               if (issue && (issue_left_q == LenW'(1))) begin
                  state_q <= StDrain;
               end
            end
            StDrain: begin
               if (last_pop) begin
                  state_q <= StIdle;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Returning read data lands unconditionally; the credit rule keeps a slot free for it.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= mem_readdata;
      end
   end

   always_comb begin
      busy              = (state_q != StIdle);
      done              = done_q;
      mem_address       = rd_addr_q;
      mem_chipselect    = issue;
      mem_write         = 1'b0;
      mem_byteenable    = 4'hF;
      mem_clken         = 1'b1;
      src_valid         = (count_q != '0);
      src_data          = fifo_mem[rd_ptr_q];
      src_startofpacket = src_valid && first_q;
      src_endofpacket   = src_valid && (out_left_q == LenW'(1));
   end

endmodule

// File: tb/tb_onchip_mem_stream_reader.sv
// Self-checking bench: transaction-level model of the expected packet, issue addresses, credit
// limit, busy/done timing, plus literal cycle and data expectations for directed cases.
module tb_onchip_mem_stream_reader;

   localparam int unsigned AW    = 10;
   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 4;

   logic          clk;
   logic          reset;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   length;
   logic          busy;
   logic          done;
   logic [AW-1:0] mem_address;
   logic          mem_chipselect;
   logic          mem_write;
   logic [3:0]    mem_byteenable;
   logic          mem_clken;
   logic [DW-1:0] mem_readdata;
   logic [DW-1:0] src_data;
   logic          src_valid;
   logic          src_ready;
   logic          src_startofpacket;
   logic          src_endofpacket;

   onchip_mem_stream_reader #(
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .start             (start),
      .base_addr         (base_addr),
      .length            (length),
      .busy              (busy),
      .done              (done),
      .mem_address       (mem_address),
      .mem_chipselect    (mem_chipselect),
      .mem_write         (mem_write),
      .mem_byteenable    (mem_byteenable),
      .mem_clken         (mem_clken),
      .mem_readdata      (mem_readdata),
      .src_data          (src_data),
      .src_valid         (src_valid),
      .src_ready         (src_ready),
      .src_startofpacket (src_startofpacket),
      .src_endofpacket   (src_endofpacket)
   );

   typedef struct {
      logic [DW-1:0] data;
      logic          sop;
      logic          eop;
   } word_t;

   logic [DW-1:0] mem_word [1024];
   word_t         exp_q[$];
   logic [DW-1:0] log_q[$];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int t0 = 0;
   int rdy_mode = 0;
   int m_done_cyc = -1;
   int m_issue_left = 0;
   int m_issued = 0;
   int m_popped = 0;
   int done_count = 0;
   int cs_total = 0;
   int sop_cyc = -1;
   int eop_cyc = -1;
   int last_done_cyc = -1;
   bit m_busy = 0;
   bit stalled_prev = 0;
   logic [AW-1:0] m_next_addr = '0;
   logic [DW-1:0] prev_data = '0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Memory slave with fixed one-cycle read latency.
   always @(posedge clk) begin
      if (mem_chipselect) mem_readdata <= mem_word[mem_address];
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic monitor();
      word_t         e;
      logic [AW-1:0] a;
      forever begin
         @(negedge clk);
         if (reset) begin
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_chipselect", mem_chipselect, 0);
            chk("rst_address", mem_address, 0);
            chk("rst_valid", src_valid, 0);
            chk("rst_sop", src_startofpacket, 0);
            chk("rst_eop", src_endofpacket, 0);
            exp_q.delete();
            m_busy = 0;
            m_done_cyc = -1;
            m_issue_left = 0;
            m_issued = 0;
            m_popped = 0;
            stalled_prev = 0;
         end else begin
            chk("busy", busy, m_busy);
            chk("done", done, cyc == m_done_cyc);
            if (done) begin
               done_count++;
               last_done_cyc = cyc;
            end
            if (stalled_prev) begin
               chk("stall_valid", src_valid, 1);
               chk("stall_data", src_data, prev_data);
            end
            if (mem_chipselect) begin
               cs_total++;
               chk("issue_allowed", m_issue_left > 0, 1);
               chk("issue_addr", mem_address, m_next_addr);
               chk("mem_consts", {mem_write, mem_byteenable, mem_clken}, 6'b0_1111_1);
               m_issue_left--;
               m_next_addr = m_next_addr + AW'(1);
               m_issued++;
               chk("credit_limit", (m_issued - m_popped) <= DEPTH, 1);
            end
            if (src_valid && src_ready) begin
               chk("word_expected", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  chk("src_data", src_data, e.data);
                  chk("src_sop", src_startofpacket, e.sop);
                  chk("src_eop", src_endofpacket, e.eop);
                  log_q.push_back(src_data);
                  if (e.sop) sop_cyc = cyc;
                  if (e.eop) begin
                     eop_cyc = cyc;
                     m_busy = 0;
                     m_done_cyc = cyc + 1;
                  end
               end
               m_popped++;
            end
            // A start counts only when idle and not in the cycle a done is due.
            if (start && !m_busy && (cyc != m_done_cyc)) begin
               if (length == '0) begin
                  m_done_cyc = cyc + 1;
               end else begin
                  a = base_addr;
                  for (int k = 0; k < int'(length); k++) begin
                     e.data = mem_word[a];
                     e.sop  = (k == 0);
                     e.eop  = (k == int'(length) - 1);
                     exp_q.push_back(e);
                     a = a + AW'(1);
                  end
                  m_busy = 1;
                  m_issue_left = int'(length);
                  m_next_addr = base_addr;
                  m_issued = 0;
                  m_popped = 0;
               end
            end
            stalled_prev = src_valid && !src_ready;
            prev_data = src_data;
         end
      end
   endtask

   task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] l);
      @(posedge clk);
      #1;
      start = 1'b1;
      base_addr = b;
      length = l;
      t0 = cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(input int bound);
      bit idle;
      idle = 0;
      for (int i = 0; i < bound && !idle; i++) begin
         @(negedge clk);
         #1;
         idle = (exp_q.size() == 0) && !m_busy && (cyc > m_done_cyc);
      end
      chk("transfer_completes", idle, 1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      int lb;
      int dc0;
      int cs0;
      int len;
      for (int i = 0; i < 1024; i++) mem_word[i] = DW'(i);
      reset = 1'b1;
      start = 1'b0;
      base_addr = '0;
      length = '0;
      src_ready = 1'b0;
      fork
         forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
               0: src_ready = 1'b1;
               1: src_ready = 1'($urandom_range(0, 1));
               default: src_ready = 1'b0;
            endcase
         end
         begin
            #2ms;
            $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
            $fatal(1, "watchdog");
         end
      join_none
      @(posedge clk);
      fork
         monitor();
      join_none
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Directed: 8 words, ready held high; exact cycle positions.
      rdy_mode = 0;
      lb = log_q.size();
      do_start(10'h010, 11'd8);
      wait_idle(100);
      chk("t1_first_word_cycle", sop_cyc - t0, 3);
      chk("t1_eop_cycle", eop_cyc - t0, 10);
      chk("t1_done_cycle", last_done_cyc - t0, 11);
      chk("t1_word_count", log_q.size() - lb, 8);
      chk("t1_first_data", log_q[lb], 32'h10);
      chk("t1_last_data", log_q[lb + 7], 32'h17);

      // Address wrap at the top of memory.
      lb = log_q.size();
      do_start(10'h3FE, 11'd4);
      wait_idle(100);
      chk("wrap_count", log_q.size() - lb, 4);
      chk("wrap_word1", log_q[lb + 1], 32'h3FF);
      chk("wrap_word2", log_q[lb + 2], 32'h000);
      chk("wrap_word3", log_q[lb + 3], 32'h001);

      // Random backpressure.
      rdy_mode = 1;
      lb = log_q.size();
      do_start(10'h040, 11'd16);
      wait_idle(500);
      chk("bp_word_count", log_q.size() - lb, 16);

      // Zero length: done in cycle 1, never busy, no reads.
      rdy_mode = 0;
      cs0 = cs_total;
      dc0 = done_count;
      do_start(10'h123, 11'd0);
      wait_idle(20);
      chk("len0_done_cycle", last_done_cyc - t0, 1);
      chk("len0_no_reads", cs_total - cs0, 0);
      chk("len0_one_done", done_count - dc0, 1);

      // Single word.
      lb = log_q.size();
      do_start(10'h2AA, 11'd1);
      wait_idle(20);
      chk("len1_count", log_q.size() - lb, 1);
      chk("len1_data", log_q[lb], 32'h2AA);

      // Second start while busy is ignored.
      rdy_mode = 1;
      lb = log_q.size();
      dc0 = done_count;
      do_start(10'h100, 11'd8);
      repeat (2) @(posedge clk);
      #1;
      start = 1'b1;
      base_addr = 10'h200;
      length = 11'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_idle(300);
      chk("busy_start_words", log_q.size() - lb, 8);
      chk("busy_start_dones", done_count - dc0, 1);

      // Start coinciding with the done pulse is ignored.
      rdy_mode = 0;
      lb = log_q.size();
      dc0 = done_count;
      do_start(10'h020, 11'd2);
      repeat (4) @(posedge clk);
      #1;
      start = 1'b1;
      base_addr = 10'h300;
      length = 11'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_idle(50);
      chk("done_cycle_done_at", last_done_cyc - t0, 5);
      chk("done_cycle_words", log_q.size() - lb, 2);
      chk("done_cycle_dones", done_count - dc0, 1);

      // Reset mid-transfer under full backpressure.
      rdy_mode = 2;
      lb = log_q.size();
      dc0 = done_count;
      do_start(10'h080, 11'd16);
      repeat (6) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("rst_now_busy", busy, 0);
      chk("rst_now_valid", src_valid, 0);
      chk("rst_now_chipselect", mem_chipselect, 0);
      chk("rst_now_address", mem_address, 0);
      chk("rst_now_sop_eop", {src_startofpacket, src_endofpacket}, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_no_words", log_q.size() - lb, 0);
      rdy_mode = 1;
      do_start(10'h050, 11'd2);
      wait_idle(50);
      chk("post_rst_count", log_q.size() - lb, 2);
      chk("post_rst_word0", log_q[lb], 32'h50);
      chk("post_rst_word1", log_q[lb + 1], 32'h51);
      chk("post_rst_dones", done_count - dc0, 1);

      // Randomised transfers.
      for (int k = 0; k < 6; k++) begin
         rdy_mode = (k % 3 == 2) ? 0 : 1;
         len = int'($urandom_range(1, 40));
         lb = log_q.size();
         do_start(AW'($urandom_range(0, 1023)), (AW + 1)'(len));
         wait_idle(len * 20 + 50);
         chk("rand_word_count", log_q.size() - lb, len);
      end

      // Full 1024-word sweep.
      rdy_mode = 1;
      lb = log_q.size();
      do_start(10'h155, 11'd1024);
      wait_idle(10000);
      chk("full_word_count", log_q.size() - lb, 1024);
      chk("full_last_data", log_q[lb + 1023], 32'h154);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
